// File: rtl/dma_seq.sv
// rtl/dma_seq.sv - DMA block-transfer sequencer driving an address generator
module dma_seq #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       abort,
    input  logic [1:0] mode,
    input  logic       dir,
    input  logic [7:0] start_addr,
    input  logic [7:0] word_count,
    input  logic       dma_req,
    input  logic       done,
    input  logic       aco_n,
    output logic [2:0] instr,
    output logic [7:0] data,
    output logic       aci,
    output logic       wci,
    output logic       dma_ack,
    output logic       busy,
    output logic       irq,
    output logic       err,
    output logic [7:0] xfer_cnt
);

    typedef enum logic [3:0] {
        S_IDLE, S_WR_CR, S_LD_ADDR, S_LD_WC, S_WAIT_REQ,
        S_XFER, S_CHECK, S_FINISH, S_ERROR
    } state_t;

    localparam logic [2:0] I_WR_CR   = 3'b000;
    localparam logic [2:0] I_LD_ADDR = 3'b101;
    localparam logic [2:0] I_LD_WC   = 3'b110;
    localparam logic [2:0] I_ENABLE  = 3'b111;
    localparam logic [2:0] I_NOP     = 3'b011;
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [1:0] mode_q, mode_d;
    logic       dir_q, dir_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wc_q, wc_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       wrap_q, wrap_d;
    logic       err_q, err_d;
    logic [7:0] xfer_cnt_q, xfer_cnt_d;
    logic [2:0] instr_q, instr_d;
    logic [7:0] data_q, data_d;
    logic       aci_q, aci_d;
    logic       wci_q, wci_d;
    logic       ack_q, ack_d;
    logic       busy_q, busy_d;
    logic       irq_q, irq_d;

    // Next-state and block-context update; abort overrides everything else
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        dir_d      = dir_q;
        addr_d     = addr_q;
        wc_d       = wc_q;
        wait_cnt_d = wait_cnt_q;
        wrap_d     = wrap_q;
        err_d      = err_q;
        xfer_cnt_d = xfer_cnt_q;
        if (abort) begin
            state_d = S_IDLE;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_ERROR: begin
                    if (start) begin
                        mode_d     = mode;
                        dir_d      = dir;
                        addr_d     = start_addr;
                        wc_d       = word_count;
                        err_d      = 1'b0;
                        wrap_d     = 1'b0;
                        xfer_cnt_d = 8'd0;
                        state_d    = S_WR_CR;
                    end
                end
                S_WR_CR:   state_d = S_LD_ADDR;
                S_LD_ADDR: state_d = S_LD_WC;
                S_LD_WC: begin
                    state_d    = S_WAIT_REQ;
                    wait_cnt_d = 8'd0;
                end
                S_WAIT_REQ: begin
                    if (dma_req) begin
                        state_d    = S_XFER;
                        xfer_cnt_d = xfer_cnt_q + 8'd1;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end
                S_XFER: begin
                    state_d = S_CHECK;
                    if (!aco_n) wrap_d = 1'b1;
                end
                S_CHECK: begin
                    if (wrap_q) begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                    end else if (done && (mode_q != 2'b11)) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d    = S_WAIT_REQ;
                        wait_cnt_d = 8'd0;
                    end
                end
                S_FINISH: state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // Moore output decode from the upcoming state so outputs are registered
    always_comb begin
        instr_d = I_NOP;
        data_d  = 8'd0;
        aci_d   = 1'b1;
        wci_d   = 1'b1;
        ack_d   = 1'b0;
        busy_d  = 1'b0;
        irq_d   = 1'b0;
        case (state_d)
            S_WR_CR: begin
                instr_d = I_WR_CR;
                data_d  = {5'b0, dir_d, mode_d};
                busy_d  = 1'b1;
            end
            S_LD_ADDR: begin
                instr_d = I_LD_ADDR;
                data_d  = addr_d;
                busy_d  = 1'b1;
            end
            S_LD_WC: begin
                instr_d = I_LD_WC;
                data_d  = wc_d;
                busy_d  = 1'b1;
            end
            S_WAIT_REQ, S_CHECK: begin
                instr_d = I_ENABLE;
                busy_d  = 1'b1;
            end
            S_XFER: begin
                instr_d = I_ENABLE;
                aci_d   = 1'b0;
                wci_d   = 1'b0;
                ack_d   = 1'b1;
                busy_d  = 1'b1;
            end
            S_FINISH: begin
                busy_d = 1'b1;
                irq_d  = 1'b1;
            end
            default: ;
        endcase
    end

    // State, context and output registers with asynchronous reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            mode_q     <= 2'd0;
            dir_q      <= 1'b0;
            addr_q     <= 8'd0;
            wc_q       <= 8'd0;
            wait_cnt_q <= 8'd0;
            wrap_q     <= 1'b0;
            err_q      <= 1'b0;
            xfer_cnt_q <= 8'd0;
            instr_q    <= I_NOP;
            data_q     <= 8'd0;
            aci_q      <= 1'b1;
            wci_q      <= 1'b1;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            dir_q      <= dir_d;
            addr_q     <= addr_d;
            wc_q       <= wc_d;
            wait_cnt_q <= wait_cnt_d;
            wrap_q     <= wrap_d;
            err_q      <= err_d;
            xfer_cnt_q <= xfer_cnt_d;
            instr_q    <= instr_d;
            data_q     <= data_d;
            aci_q      <= aci_d;
            wci_q      <= wci_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            irq_q      <= irq_d;
        end
    end

    assign instr    = instr_q;
    assign data     = data_q;
    assign aci      = aci_q;
    assign wci      = wci_q;
    assign dma_ack  = ack_q;
    assign busy     = busy_q;
    assign irq      = irq_q;
    assign err      = err_q;
    assign xfer_cnt = xfer_cnt_q;

endmodule

// File: doc/dma_seq.md
DMA_SEQ -- requirements
Module: dma_seq

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the number of WAIT_REQ cycles without dma_req before error (legal 1..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, a request to begin a block transfer, sampled in IDLE or ERROR.
REQ-005 SHALL have port abort, input, 1, which terminates any operation.
REQ-006 SHALL have ports mode (input, 2) and dir (input, 1), captured at start; dir=1 means the address decrements.
REQ-007 SHALL have ports start_addr (input, 8) and word_count (input, 8), captured at start.
REQ-008 SHALL have port dma_req, input, 1, the peripheral transfer request (level).
REQ-009 SHALL have port done, input, 1, the terminal-count flag from the address generator.
REQ-010 SHALL have port aco_n, input, 1, the address-counter carry; low means the address is about to wrap.
REQ-011 SHALL have ports instr (output, 3) and data (output, 8), the instruction and data bus driven to the address generator.
REQ-012 SHALL have ports aci (output, 1) and wci (output, 1), counter carry-ins; 0 means count, 1 means hold.
REQ-013 SHALL have ports dma_ack, busy, irq and err (output, 1 each), and xfer_cnt (output, 8).

Function
REQ-014 SHALL use these instruction codes: 000 write control register, 101 load address, 110 load word count, 111 enable counters, 011 no-op read.
REQ-015 SHALL register all outputs and implement a Moore FSM with states IDLE, WR_CR, LD_ADDR, LD_WC, WAIT_REQ, XFER, CHECK, FINISH, ERROR.
REQ-016 SHALL drive, in IDLE and ERROR: instr=011, data=0, aci=wci=1, dma_ack=0, busy=0.
REQ-017 SHALL, on start sampled in IDLE or ERROR with abort=0: capture the inputs, clear err and xfer_cnt, and enter WR_CR next cycle.
REQ-018 SHALL drive, in WR_CR, instr=000 and data={5'b0,dir,mode}.
REQ-019 SHALL drive, in LD_ADDR, instr=101 and data=start_addr.
REQ-020 SHALL drive, in LD_WC, instr=110 and data=word_count; the word_count value passes through unmodified, 0 included.
REQ-021 SHALL sequence WR_CR->LD_ADDR->LD_WC->WAIT_REQ on consecutive cycles, with busy=1 from WR_CR through FINISH.
REQ-022 SHALL drive, in WAIT_REQ, instr=111 with aci=wci=1, and count the cycles spent there.
REQ-023 SHALL clear that cycle counter on each entry to WAIT_REQ.
REQ-024 SHALL, in WAIT_REQ with dma_req=1, go to XFER next cycle.
REQ-025 SHALL, in WAIT_REQ when the cycle counter reaches TIMEOUT with no dma_req, go to ERROR.
REQ-026 SHALL drive, in XFER for exactly one cycle: instr=111, aci=wci=0, dma_ack=1, and increment xfer_cnt (255 wraps to 0).
REQ-027 SHALL sample aco_n during XFER; if aco_n=0, set a wrap flag that routes CHECK to ERROR.
REQ-028 SHALL drive, in CHECK, instr=111 with aci=wci=1.
REQ-029 SHALL, from CHECK, go to ERROR if the wrap flag is set, else to FINISH if done=1, else to WAIT_REQ.
REQ-030 SHALL assert irq for exactly the one FINISH cycle, then go to IDLE.
REQ-031 SHALL set err=1 in ERROR and hold it until start or abort.
REQ-032 SHALL, with dma_req held high, give one transfer per 3 cycles (WAIT_REQ, XFER, CHECK); a request sampled in any other state is ignored.
REQ-033 SHALL ignore start while busy=1.
REQ-034 SHALL, on abort in any state, go to IDLE next cycle: no irq, err cleared, xfer_cnt held.
REQ-035 SHALL give abort priority over a simultaneous start and over a dma_req.
REQ-036 SHALL, in mode 11, never finish on done; only abort, timeout or wrap ends the block.

Reset
REQ-037 SHALL, when reset_n=0, immediately force IDLE and outputs instr=011, data=0, aci=wci=1, dma_ack=busy=irq=err=0, xfer_cnt=0, and clear the wrap flag and cycle counter, regardless of state (including mid-XFER).
REQ-038 SHALL leave reset on the first rising clk edge after reset_n=1; start must not be acted on before that edge.

Verification
REQ-039 SHALL cover this normal block: mode=00, dir=0, start_addr=0x10, word_count=3, dma_req high, done high on the 3rd CHECK -> instr/data sequence 000/0x00, 101/0x10, 110/0x03, then 111; 3 dma_ack pulses 3 cycles apart; irq one cycle; xfer_cnt=3; busy low after FINISH.
REQ-040 SHALL cover timeout: TIMEOUT=4 and dma_req held low -> ERROR after 4 WAIT_REQ cycles, err=1, busy=0, no dma_ack.
REQ-041 SHALL cover address wrap: aco_n=0 during the 2nd XFER -> CHECK goes to ERROR, err=1, xfer_cnt=2, no irq.
REQ-042 SHALL cover abort: abort during WAIT_REQ -> IDLE next cycle, busy=0, irq=0; a start on the same cycle as abort is ignored.
REQ-043 SHALL cover reset mid-transfer: reset_n low during XFER -> all outputs at reset values with no clock edge; a new start then runs a full sequence from WR_CR.
REQ-044 SHALL cover start while busy: a second start during WAIT_REQ with new start_addr=0x80 -> ignored, and the block finishes on the original parameters.
